// File: rtl/bist_tpg.sv
// BIST test-pattern generator: a 128-bit Fibonacci LFSR streams NUM_PATTERNS vectors per start
// over valid/ready. Optional macro BIST_TPG_SEED_PORT_EN adds a runtime seed_in port.
module bist_tpg #(
    parameter int          NUM_PATTERNS = 62,
    parameter int          CNT_W        = 8,
    parameter logic [127:0] SEED        = 128'h1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef BIST_TPG_SEED_PORT_EN
    input  logic [127:0]     seed_in,
`endif
    input  logic             start,
    input  logic             pat_ready,
    output logic [127:0]     pattern,
    output logic             pat_valid,
    output logic             ora_enable,
    output logic [CNT_W-1:0] pat_count,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic         xfer;
    logic         last;
    logic [127:0] load_seed;
    logic         fb;

    assign pat_valid  = (state == RUN);
    assign ora_enable = pat_valid & pat_ready;
    assign busy       = (state == LOAD) || (state == RUN);
    assign done       = (state == DONE);
    assign xfer       = ora_enable;
    assign last       = (pat_count == CNT_W'(NUM_PATTERNS - 1));
    assign fb         = pattern[127] ^ pattern[125] ^ pattern[100] ^ pattern[98];

`ifdef BIST_TPG_SEED_PORT_EN
    logic [127:0] seed_q;

    // seed_in is captured on the same edge that samples start; zero would lock the LFSR up
    always_ff @(posedge clk) begin
        if (rst)
            seed_q <= SEED;
        else if (((state == IDLE) || (state == DONE)) && start)
            seed_q <= (seed_in == '0) ? SEED : seed_in;
    end
    assign load_seed = seed_q;
`else
    assign load_seed = SEED;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (xfer && last) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // pattern is the LFSR state itself; it keeps the last stepped value through DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern   <= '0;
            pat_count <= '0;
        end else if (state == LOAD) begin
            pattern   <= load_seed;
            pat_count <= '0;
        end else if (xfer) begin
            pattern   <= {pattern[126:0], fb};
            pat_count <= pat_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_bist_tpg.sv
// Scoreboard bench for bist_tpg: the driver pushes each run's expected vector stream,
// a negedge monitor pops and compares on every transfer.
module tb_bist_tpg;
    localparam int NP = 62;
    localparam int CW = 8;

    logic          clk = 0;
    logic          rst = 1;
    logic          start = 0;
    logic          pat_ready = 0;
    logic [127:0]  pattern;
    logic          pat_valid, ora_enable, busy, done;
    logic [CW-1:0] pat_count;
`ifdef BIST_TPG_SEED_PORT_EN
    logic [127:0]  seed_in = '0;
`endif

    bist_tpg #(.NUM_PATTERNS(NP), .CNT_W(CW), .SEED(128'h1)) dut (
        .clk(clk), .rst(rst),
`ifdef BIST_TPG_SEED_PORT_EN
        .seed_in(seed_in),
`endif
        .start(start), .pat_ready(pat_ready), .pattern(pattern), .pat_valid(pat_valid),
        .ora_enable(ora_enable), .pat_count(pat_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]  pat;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   xfers = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, want);
        end
    endtask

    // Reference LFSR: shift left, new bit is the XOR of taps 127,125,100,98
    function automatic logic [127:0] lfsr_next(input logic [127:0] s);
        return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
    endfunction

    task automatic push_run(input logic [127:0] seed);
        logic [127:0] s;
        exp_t x;
        s = seed;
        for (int i = 0; i < NP; i++) begin
            x.pat = s;
            x.cnt = CW'(i);
            exp_q.push_back(x);
            s = lfsr_next(s);
        end
    endtask

    task automatic do_start(input logic [127:0] exp_seed);
        @(posedge clk); #1 start = 1;
        push_run(exp_seed);
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            pat_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        chk("run_completes", done, 1);
        pat_ready = 1;
    endtask

    task automatic wait_xfers(input int target, input string nm);
        int n = 0;
        while (xfers < target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, (xfers >= target), 1);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_pattern"}, pattern, 0);
        chk({nm, "_valid"}, pat_valid, 0);
        chk({nm, "_ora"}, ora_enable, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_count"}, pat_count, 0);
    endtask

    // Monitor: every accepted vector must match the next scoreboard entry
    always @(negedge clk) begin
        if (!rst) begin
            if (pat_valid && pat_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_xfer got=%0h expected=none", pattern);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_pattern", pattern, e.pat);
                    chk("xfer_count", pat_count, e.cnt);
                    chk("ora_on", ora_enable, 1);
                end
                xfers++;
            end else begin
                chk("ora_off", ora_enable, 0);
            end
        end
    end

    initial begin
        logic [127:0]  p0;
        logic [CW-1:0] c0;
        int            base;
        int            n;

        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        rst = 0;

        // T2 latency and first vectors
        pat_ready = 1;
        do_start(128'h1);
        @(negedge clk);
        chk("load_valid", pat_valid, 0);
        chk("load_busy", busy, 1);
        @(negedge clk);
        chk("first_valid", pat_valid, 1);
        chk("first_pattern", pattern, 128'h1);
        @(negedge clk);
        chk("second_pattern", pattern, 128'h2);
        @(negedge clk);
        chk("third_pattern", pattern, 128'h4);

        // T3 backpressure, with a start pulse that must be ignored
        wait_xfers(5, "reach_5_xfers");
        pat_ready = 0;
        start = 1;
        @(negedge clk);
        p0 = pattern;
        c0 = pat_count;
        chk("stall_count", c0, CW'(xfers));
        chk("stall_pattern", p0, (exp_q.size() != 0) ? exp_q[0].pat : 128'hx);
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_pattern", pattern, p0);
            chk("stall_hold_count", pat_count, c0);
            chk("stall_busy", busy, 1);
        end

        // T4 completion under random backpressure
        wait_done(1);
        @(negedge clk);
        chk("done_flag", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", pat_valid, 0);
        chk("done_count", pat_count, NP);
        chk("done_xfers", xfers, NP);
        chk("done_queue_empty", exp_q.size(), 0);

        // Restart from DONE, then T5 reset after 10 transfers
        base = xfers;
        do_start(128'h1);
        wait_xfers(base + 10, "reach_10_xfers");
        rst = 1;
        pat_ready = 0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("midrun_reset");
        rst = 0;

        // Fresh run after reset, full throughput
        pat_ready = 1;
        do_start(128'h1);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("throughput_cycles", n, NP + 1);
        chk("rerun_queue_empty", exp_q.size(), 0);

`ifdef BIST_TPG_SEED_PORT_EN
        // T6 runtime seed, captured at the start sample
        seed_in = 128'hA5;
        do_start(128'hA5);
        seed_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        @(negedge clk);
        chk("seed_first_pattern", pattern, 128'hA5);
        wait_done(1);
        seed_in = '0;
        do_start(128'h1);
        @(negedge clk);
        @(negedge clk);
        chk("zero_seed_first_pattern", pattern, 128'h1);
        wait_done(0);
        @(negedge clk);
        chk("seed_queue_empty", exp_q.size(), 0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
